// File: rtl/rat_pkg.sv
// rat_pkg: shared defaults, rename entry type and helpers for the RAT register file
package rat_pkg;
   localparam int RAT_XLEN  = 32;
   localparam int RAT_TAG_W = 3;
   typedef struct packed {
      logic [RAT_XLEN-1:0]  data;
      logic [RAT_TAG_W-1:0] tag;
      logic                 busy;
   } rat_entry_t;
   function automatic logic is_zero_reg(input logic [31:0] idx);
      return idx == 32'd0;
   endfunction
endpackage

// File: rtl/rat_bypass.sv
// rat_bypass: one read port, merges stored entry with same-cycle commit data
module rat_bypass
   import rat_pkg::*;
#(
   parameter int XLEN  = RAT_XLEN,
   parameter int TAG_W = RAT_TAG_W,
   parameter int IDX_W = 5
) (
   input  logic [IDX_W-1:0] i_src,
   input  logic [XLEN-1:0]  i_data,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_busy,
   input  logic             i_commit_valid,
   input  logic [IDX_W-1:0] i_commit_dest,
   input  logic [TAG_W-1:0] i_commit_tag,
   input  logic [XLEN-1:0]  i_commit_data,
   output logic [XLEN-1:0]  o_data,
   output logic             o_ready,
   output logic [TAG_W-1:0] o_tag
);
   logic w_hit;
   // r0 is never written, so its stored entry already reads as 0/ready/tag 0
   always_comb begin
      w_hit   = i_commit_valid && i_commit_dest == i_src && !is_zero_reg(32'(i_src));
      o_data  = w_hit ? i_commit_data : i_data;
      o_ready = !i_busy || (w_hit && i_tag == i_commit_tag);
      o_tag   = i_tag;
   end
endmodule

// File: rtl/rat_regfile.sv
// rat_regfile: architectural register file with busy/tag rename state and commit bypass
module rat_regfile
   import rat_pkg::*;
#(
   parameter int XLEN     = RAT_XLEN,
   parameter int NUM_REGS = 32,
   parameter int TAG_W    = RAT_TAG_W,
   parameter int NUM_RD   = 2,
   parameter int IDX_W    = $clog2(NUM_REGS),
   parameter int CNT_W    = $clog2(NUM_REGS+1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_alloc_valid,
   input  logic [IDX_W-1:0]        i_alloc_dest,
   input  logic [TAG_W-1:0]        i_alloc_tag,
   input  logic                    i_commit_valid,
   input  logic [IDX_W-1:0]        i_commit_dest,
   input  logic [TAG_W-1:0]        i_commit_tag,
   input  logic [XLEN-1:0]         i_commit_data,
   input  logic                    i_flush,
   input  logic [NUM_RD*IDX_W-1:0] i_rd_src,
   output logic [NUM_RD*XLEN-1:0]  o_rd_data,
   output logic [NUM_RD-1:0]       o_rd_ready,
   output logic [NUM_RD*TAG_W-1:0] o_rd_tag,
   input  logic [IDX_W-1:0]        i_dbg_src,
   output logic [XLEN-1:0]         o_dbg_data,
   output logic [CNT_W-1:0]        o_busy_cnt
);
   logic [XLEN-1:0]     r_data [NUM_REGS];
   logic [TAG_W-1:0]    r_tag  [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [CNT_W-1:0]    r_cnt;
   logic w_alloc, w_commit, w_clr, w_inc, w_dec;
   // Qualify requests: r0 is hardwired, flush drops the alloc; a commit clears busy
   // only when it matches the current (youngest) rename
   always_comb begin
      w_alloc  = i_alloc_valid && !i_flush && !is_zero_reg(32'(i_alloc_dest));
      w_commit = i_commit_valid && !is_zero_reg(32'(i_commit_dest));
      w_clr    = w_commit && r_busy[i_commit_dest] && r_tag[i_commit_dest] == i_commit_tag;
      w_inc    = w_alloc && !r_busy[i_alloc_dest];
      w_dec    = w_clr && !(w_alloc && i_alloc_dest == i_commit_dest);
   end
   // State update; an alloc overrides a same-cycle commit clear on the same register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '{default: '0};
         r_tag  <= '{default: '0};
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_commit) r_data[i_commit_dest] <= i_commit_data;
         if (i_flush) r_busy <= '0;
         else begin
            if (w_clr) r_busy[i_commit_dest] <= 1'b0;
            if (w_alloc) begin
               r_busy[i_alloc_dest] <= 1'b1;
               r_tag[i_alloc_dest]  <= i_alloc_tag;
            end
         end
         r_cnt <= i_flush ? '0 : r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
      end
   end
   assign o_dbg_data = r_data[i_dbg_src];
   assign o_busy_cnt = r_cnt;
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [IDX_W-1:0] w_src;
      assign w_src = i_rd_src[g*IDX_W +: IDX_W];
      rat_bypass #(.XLEN(XLEN), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_byp (
         .i_src         (w_src),
         .i_data        (r_data[w_src]),
         .i_tag         (r_tag[w_src]),
         .i_busy        (r_busy[w_src]),
         .i_commit_valid(i_commit_valid),
         .i_commit_dest (i_commit_dest),
         .i_commit_tag  (i_commit_tag),
         .i_commit_data (i_commit_data),
         .o_data        (o_rd_data[g*XLEN +: XLEN]),
         .o_ready       (o_rd_ready[g]),
         .o_tag         (o_rd_tag[g*TAG_W +: TAG_W])
      );
   end
endmodule

// File: tb/tb_rat_regfile.sv
// tb_rat_regfile: directed self-checking bench for rat_regfile
module tb_rat_regfile;
   logic clk = 1'b0, rst = 1'b1;
   logic alloc_valid, commit_valid, flush;
   logic [4:0] alloc_dest, commit_dest, dbg_src, src0, src1;
   logic [2:0] alloc_tag, commit_tag;
   logic [31:0] commit_data, dbg_data;
   logic [63:0] rd_data;
   logic [1:0] rd_ready;
   logic [5:0] rd_tag, busy_cnt;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rat_regfile dut (
      .clk(clk), .rst(rst),
      .i_alloc_valid(alloc_valid), .i_alloc_dest(alloc_dest), .i_alloc_tag(alloc_tag),
      .i_commit_valid(commit_valid), .i_commit_dest(commit_dest), .i_commit_tag(commit_tag),
      .i_commit_data(commit_data), .i_flush(flush), .i_rd_src({src1, src0}),
      .o_rd_data(rd_data), .o_rd_ready(rd_ready), .o_rd_tag(rd_tag),
      .i_dbg_src(dbg_src), .o_dbg_data(dbg_data), .o_busy_cnt(busy_cnt)
   );

   task automatic idle();
      alloc_valid = 0; alloc_dest = 0; alloc_tag = 0;
      commit_valid = 0; commit_dest = 0; commit_tag = 0; commit_data = 0;
      flush = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle(); src0 = 5; src1 = 0; dbg_src = 5; rst = 1;
      step(); step(); rst = 0; #1;
      checks++; if (rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", rd_data[31:0]); end
      checks++; if (rd_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", rd_ready); end
      checks++; if (rd_tag !== 6'd0) begin errors++; $display("FAIL reset_tag got %h exp 0", rd_tag); end
      checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
      checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_dbg got %h exp 0", dbg_data); end
   endtask

   task automatic test_bypass();
      alloc_valid = 1; alloc_dest = 3; alloc_tag = 2; step(); idle();
      src0 = 3; #1;
      checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL byp_cnt1 got %0d exp 1", busy_cnt); end
      checks++; if (rd_ready[0] !== 1'b0 || rd_tag[2:0] !== 3'd2) begin errors++; $display("FAIL byp_pending got rdy %b tag %0d exp 0/2", rd_ready[0], rd_tag[2:0]); end
      commit_valid = 1; commit_dest = 3; commit_tag = 2; commit_data = 32'hDEADBEEF; #1;
      checks++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin errors++; $display("FAIL byp_fwd got %h/%b exp deadbeef/1", rd_data[31:0], rd_ready[0]); end
      step(); idle(); dbg_src = 3; #1;
      checks++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin errors++; $display("FAIL byp_after got %h/%b exp deadbeef/1", rd_data[31:0], rd_ready[0]); end
      checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_dbg got %h exp deadbeef", dbg_data); end
      checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL byp_cnt0 got %0d exp 0", busy_cnt); end
   endtask

   task automatic test_younger_rename();
      alloc_valid = 1; alloc_dest = 4; alloc_tag = 1; step();
      alloc_tag = 5; step(); idle(); src0 = 4; #1;
      checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL yng_cnt got %0d exp 1", busy_cnt); end
      commit_valid = 1; commit_dest = 4; commit_tag = 1; commit_data = 7; #1;
      checks++; if (rd_data[31:0] !== 32'd7 || rd_ready[0] !== 1'b0 || rd_tag[2:0] !== 3'd5) begin errors++; $display("FAIL yng_fwd got %h/%b/%0d exp 7/0/5", rd_data[31:0], rd_ready[0], rd_tag[2:0]); end
      step(); idle(); #1;
      checks++; if (rd_data[31:0] !== 32'd7 || rd_ready[0] !== 1'b0 || rd_tag[2:0] !== 3'd5) begin errors++; $display("FAIL yng_after got %h/%b/%0d exp 7/0/5", rd_data[31:0], rd_ready[0], rd_tag[2:0]); end
      checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL yng_cnt2 got %0d exp 1", busy_cnt); end
      commit_valid = 1; commit_dest = 4; commit_tag = 5; commit_data = 8; step(); idle(); #1;
      checks++; if (busy_cnt !== 6'd0 || rd_ready[0] !== 1'b1) begin errors++; $display("FAIL yng_drain got %0d/%b exp 0/1", busy_cnt, rd_ready[0]); end
   endtask

   task automatic test_same_cycle();
      alloc_valid = 1; alloc_dest = 6; alloc_tag = 0; step(); idle();
      alloc_valid = 1; alloc_dest = 6; alloc_tag = 3;
      commit_valid = 1; commit_dest = 6; commit_tag = 0; commit_data = 9; src0 = 6; #1;
      checks++; if (rd_data[31:0] !== 32'd9 || rd_ready[0] !== 1'b1 || rd_tag[2:0] !== 3'd0) begin errors++; $display("FAIL same_fwd got %h/%b/%0d exp 9/1/0", rd_data[31:0], rd_ready[0], rd_tag[2:0]); end
      step(); idle(); #1;
      checks++; if (rd_data[31:0] !== 32'd9 || rd_ready[0] !== 1'b0 || rd_tag[2:0] !== 3'd3) begin errors++; $display("FAIL same_after got %h/%b/%0d exp 9/0/3", rd_data[31:0], rd_ready[0], rd_tag[2:0]); end
      checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL same_cnt got %0d exp 1", busy_cnt); end
      commit_valid = 1; commit_dest = 6; commit_tag = 3; commit_data = 10; step(); idle(); #1;
      checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL same_drain got %0d exp 0", busy_cnt); end
   endtask

   task automatic test_flush();
      alloc_valid = 1; alloc_dest = 1; alloc_tag = 1; step();
      alloc_dest = 2; alloc_tag = 2; step();
      alloc_dest = 7; alloc_tag = 4; step(); idle(); #1;
      checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL fl_cnt3 got %0d exp 3", busy_cnt); end
      flush = 1; alloc_valid = 1; alloc_dest = 8; alloc_tag = 6;
      commit_valid = 1; commit_dest = 2; commit_tag = 7; commit_data = 32'h55;
      step(); idle(); src0 = 8; src1 = 2; #1;
      checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL fl_cnt got %0d exp 0", busy_cnt); end
      checks++; if (rd_ready !== 2'b11 || rd_tag[2:0] !== 3'd0 || rd_tag[5:3] !== 3'd2) begin errors++; $display("FAIL fl_r8r2 got rdy %b tags %h exp 11 r8=0 r2=2", rd_ready, rd_tag); end
      checks++; if (rd_data[63:32] !== 32'h55) begin errors++; $display("FAIL fl_r2data got %h exp 55", rd_data[63:32]); end
      src0 = 1; src1 = 7; #1;
      checks++; if (rd_ready !== 2'b11 || rd_tag[5:3] !== 3'd4) begin errors++; $display("FAIL fl_r1r7 got rdy %b tag %0d exp 11/4", rd_ready, rd_tag[5:3]); end
   endtask

   task automatic test_zero_reg();
      alloc_valid = 1; alloc_dest = 5; alloc_tag = 1; step(); idle();
      alloc_valid = 1; alloc_dest = 0; alloc_tag = 3;
      commit_valid = 1; commit_dest = 0; commit_tag = 3; commit_data = 32'hFF; src0 = 0; #1;
      checks++; if (rd_data[31:0] !== 32'd0 || rd_ready[0] !== 1'b1) begin errors++; $display("FAIL z_fwd got %h/%b exp 0/1", rd_data[31:0], rd_ready[0]); end
      step(); idle(); dbg_src = 0; #1;
      checks++; if (rd_data[31:0] !== 32'd0 || rd_ready[0] !== 1'b1 || rd_tag[2:0] !== 3'd0) begin errors++; $display("FAIL z_after got %h/%b/%0d exp 0/1/0", rd_data[31:0], rd_ready[0], rd_tag[2:0]); end
      checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL z_dbg got %h exp 0", dbg_data); end
      checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL z_cnt got %0d exp 1", busy_cnt); end
   endtask

   task automatic test_reset_mid();
      rst = 1; alloc_valid = 1; alloc_dest = 9; alloc_tag = 2; step(); rst = 0; idle();
      src0 = 5; src1 = 9; dbg_src = 3; #1;
      checks++; if (busy_cnt !== 6'd0 || rd_ready !== 2'b11) begin errors++; $display("FAIL rm_state got %0d/%b exp 0/11", busy_cnt, rd_ready); end
      checks++; if (dbg_data !== 32'd0 || rd_tag !== 6'd0) begin errors++; $display("FAIL rm_data got %h/%h exp 0/0", dbg_data, rd_tag); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_younger_rename();
      test_same_cycle();
      test_flush();
      test_zero_reg();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rat_regfile.md
# rat_regfile

Parametrised architectural register file with per-register rename state (busy bit plus ROB tag) for the out-of-order core. It sits between dispatch and the reorder buffer. It serves multiple source-operand read ports with commit-data bypass and accepts one allocation and one commit per cycle. It also provides a single-cycle flush for misprediction recovery and a registered count of pending registers.

## Interface
Parameters:
- XLEN, 32, data width
- NUM_REGS, 32, architectural register count; power of two, at least 2
- TAG_W, 3, ROB tag width
- NUM_RD, 2, number of operand read ports
- Derived: IDX_W = $clog2(NUM_REGS); CNT_W = $clog2(NUM_REGS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  1  dispatch renames alloc_dest
- alloc_dest  in  IDX_W  destination register being renamed
- alloc_tag  in  TAG_W  ROB tag of the renaming instruction
- commit_valid  in  1  ROB commits a result
- commit_dest  in  IDX_W  register being written
- commit_tag  in  TAG_W  ROB tag of the committing entry
- commit_data  in  XLEN  committed value
- flush  in  1  discard all speculative renames
- rd_src  in  NUM_RD x IDX_W  operand register indices
- rd_data  out  NUM_RD x XLEN  operand values
- rd_ready  out  NUM_RD  1 = value final; 0 = wait on rd_tag
- rd_tag  out  NUM_RD x TAG_W  producer tag when not ready
- dbg_src  in  IDX_W  debug/memory-side read index
- dbg_data  out  XLEN  data array contents, no bypass
- busy_cnt  out  CNT_W  registered number of busy registers

## Operation
- Per-register state: data, tag, busy. Reset sets data=0, tag=0, busy=0 for every register.
- Register 0 is hardwired:
  - Writes and allocations to it are ignored.
  - Reads return data 0, ready 1, tag 0.
- Commit (commit_valid, dest≠0):
  - data[dest] ← commit_data unconditionally.
  - busy[dest] is cleared only if busy and tag[dest]==commit_tag. A younger rename stays pending.
- Alloc (alloc_valid, dest≠0, flush=0): busy[dest] ← 1 and tag[dest] ← alloc_tag.
- Alloc and commit to the same register in the same cycle:
  - The data write happens.
  - Busy and tag take the alloc values.
- Flush:
  - All busy bits clear next cycle. Tags and data are retained.
  - A same-cycle commit still writes data.
  - A same-cycle alloc is dropped.
- Reads are combinational from the pre-edge state, with bypass per port i:
  - If commit_valid, commit_dest==rd_src[i] and rd_src[i]≠0: rd_data=commit_data.
  - If additionally busy and tag matches commit_tag: rd_ready=1.
  - Otherwise rd_ready=!busy.
  - rd_tag is always tag[rd_src[i]].
- Same-cycle alloc is never forwarded to reads. A dispatching instruction therefore reads its own destination's old mapping.
- busy_cnt counts set busy bits after each edge:
  - +1 on alloc to a non-busy register.
  - -1 on tag-matched commit.
  - Net 0 when both hit the same register.
  - Forced to 0 on flush or reset.

## Timing
- Reads and bypass: 0-cycle combinational latency.
- Alloc, commit, flush: visible in stored state the cycle after the edge.
- busy_cnt: registered, reflects state after the same edge.
- Reset mid-operation: all state is reset on the next edge; inputs in that cycle are ignored.
- Output values in reset state:
  - rd_data=0, rd_ready=1, rd_tag=0.
  - dbg_data=0, busy_cnt=0.
- No handshake back-pressure; every valid input is accepted in its cycle.

## Structure
- Shared package rat_pkg: XLEN/TAG_W defaults, typedef rat_entry_t {data, tag, busy}, function is_zero_reg.
- Sub-module rat_bypass: one instance per read port. It takes stored entry plus commit inputs and produces rd_data/rd_ready/rd_tag.
- Top level holds the entry array, update logic and busy_cnt.

## Test plan
- Reset, then read r5 on port 0 -> rd_data=0, rd_ready=1, busy_cnt=0.
- Alloc r3 tag 2; next cycle commit r3 tag 2 data 0xDEADBEEF while reading r3 -> bypass data 0xDEADBEEF, ready=1 same cycle; after the edge ready=1 and busy_cnt=0.
- Alloc r4 tag 1, then alloc r4 tag 5, then commit r4 tag 1 data 7 -> data=7 but ready=0, rd_tag=5, busy_cnt=1.
- Same cycle alloc r6 tag 3 and commit r6 (old tag 0, busy) data 9 -> next cycle data=9, busy=1, tag=3.
- Alloc r1, r2, r7, then flush with simultaneous alloc r8 and commit r2 data 0x55 -> all ready=1, r8 not busy, r2 data 0x55, busy_cnt=0.
- Alloc/commit to r0 with data 0xFF -> reads r0 data 0, ready 1, busy_cnt unchanged.
